ddr_pmon_ctrl: RTL

- Measurement sequencer for the process-monitor digital block. Drives its NOR and NAND enables, waits for each frequency-detect done, and captures the 24-bit counts.
- Averages 2^N samples per channel and publishes one result pair per sequence.
- Supports single-shot and periodic operation, with a per-phase timeout.
- Sits in the refclk domain between the CSR block and the pmon digital block. All done/count inputs are refclk-synchronous.

---
 rtl/ddr_pmon_ctrl_if.sv | 35 +++
 rtl/ddr_pmon_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_pmon_ctrl_if.sv
// ----------------------------------------------------------------------------
// ddr_pmon_ctrl_if
// Handshake bundle between the pmon measurement sequencer and the
// process-monitor digital block (refclk domain).
//   en_nor / en_nand       : measurement enables, driven by the sequencer
//   done_nor / done_nand   : frequency-detect done, driven by the pmon block
//   count_nor / count_nand : 24-bit counts, valid while the matching done is high
// Modports: master = sequencer side, slave = pmon block side.
// ----------------------------------------------------------------------------
interface ddr_pmon_ctrl_if;
    logic        en_nor;
    logic        en_nand;
    logic        done_nor;
    logic        done_nand;
    logic [23:0] count_nor;
    logic [23:0] count_nand;

    modport master (
        output en_nor,
        output en_nand,
        input  done_nor,
        input  done_nand,
        input  count_nor,
        input  count_nand
    );

    modport slave (
        input  en_nor,
        input  en_nand,
        output done_nor,
        output done_nand,
        output count_nor,
        output count_nand
    );
endinterface

// File: rtl/ddr_pmon_ctrl.sv
// ----------------------------------------------------------------------------
// ddr_pmon_ctrl
// Process-monitor measurement sequencer. Runs 2^avg_log2 NOR and/or NAND
// measurements, accumulates the counts, and publishes the averaged pair with
// a one-cycle valid pulse. Single-shot or periodic, with per-phase timeout.
// Ports:
//   i_refclk, i_refclk_rst    : clock, async active-high reset
//   i_start, i_abort          : start pulse, abort level (abort wins)
//   i_cfg_*                   : channel select, periodic mode, interval,
//                               averaging log2 (clamped), timeout (0 = off)
//   pmon                      : enables out, done/count in
//   o_busy                    : sequence active (includes WAIT)
//   o_result_valid/_nor/_nand : averaged results and update pulse
//   o_timeout_err/_ch         : sticky timeout flag and offending channel
// ----------------------------------------------------------------------------
module ddr_pmon_ctrl #(
    parameter int MAX_AVG_LOG2 = 4,
    parameter int TMR_W        = 16
) (
    input  logic              i_refclk,
    input  logic              i_refclk_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_cfg_sel,
    input  logic              i_cfg_continuous,
    input  logic [TMR_W-1:0]  i_cfg_interval,
    input  logic [2:0]        i_cfg_avg_log2,
    input  logic [TMR_W-1:0]  i_cfg_timeout,
    ddr_pmon_ctrl_if.master   pmon,
    output logic              o_busy,
    output logic              o_result_valid,
    output logic [23:0]       o_result_nor,
    output logic [23:0]       o_result_nand,
    output logic              o_timeout_err,
    output logic              o_timeout_ch
);
    localparam int          ACC_W   = 24 + MAX_AVG_LOG2;
    localparam int          SMP_W   = MAX_AVG_LOG2 + 1;
    localparam logic [2:0]  AVG_MAX = 3'(MAX_AVG_LOG2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_REL  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4,
        S_WAIT = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               ch_q, ch_d;              // 0 = NOR, 1 = NAND
    logic [1:0]         sel_q, sel_d;
    logic [2:0]         avg_q, avg_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;            // phase / interval counter
    logic [ACC_W-1:0]   acc_nor_q, acc_nor_d;
    logic [ACC_W-1:0]   acc_nand_q, acc_nand_d;
    logic               en_nor_q, en_nor_d;
    logic               en_nand_q, en_nand_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [23:0]        res_nor_q, res_nor_d;
    logic [23:0]        res_nand_q, res_nand_d;
    logic               err_q, err_d;
    logic               err_ch_q, err_ch_d;

    logic [2:0]         avg_clamp_s;
    logic               done_cur_s;
    logic [TMR_W:0]     tmr_inc_s;
    logic [TMR_W-1:0]   tmr_sat_s;
    logic               tmo_hit_s;
    logic [TMR_W:0]     ival_s;
    logic [SMP_W-1:0]   smp_target_s;
    logic               first_ch_s;
    logic               launch_s;

    assign avg_clamp_s  = (i_cfg_avg_log2 > AVG_MAX) ? AVG_MAX : i_cfg_avg_log2;
    assign done_cur_s   = ch_q ? pmon.done_nand : pmon.done_nor;
    assign tmr_inc_s    = {1'b0, tmr_q} + {{TMR_W{1'b0}}, 1'b1};
    // Saturate so a disabled timeout never wraps back to the "first cycle" value
    assign tmr_sat_s    = (&tmr_q) ? tmr_q : tmr_inc_s[TMR_W-1:0];
    assign tmo_hit_s    = (i_cfg_timeout != {TMR_W{1'b0}}) && (tmr_inc_s >= {1'b0, i_cfg_timeout});
    assign ival_s       = (i_cfg_interval == {TMR_W{1'b0}}) ? {{TMR_W{1'b0}}, 1'b1} : {1'b0, i_cfg_interval};
    assign smp_target_s = SMP_W'(1) << avg_q;
    assign first_ch_s   = ~i_cfg_sel[0];

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        sel_d      = sel_q;
        avg_d      = avg_q;
        smp_d      = smp_q;
        tmr_d      = tmr_sat_s;
        acc_nor_d  = acc_nor_q;
        acc_nand_d = acc_nand_q;
        en_nor_d   = 1'b0;
        en_nand_d  = 1'b0;
        res_nor_d  = res_nor_q;
        res_nand_d = res_nand_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        err_ch_d   = err_ch_q;
        launch_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start && (i_cfg_sel != 2'b00)) begin
                    err_d    = 1'b0;
                    launch_s = 1'b1;
                end else begin
                    tmr_d = {TMR_W{1'b0}};
                end
            end
            S_RUN: begin
                // tmr_q == 0 is the first enabled cycle: a done seen then is stale
                if (done_cur_s && (tmr_q != {TMR_W{1'b0}})) begin
                    if (ch_q) begin
                        acc_nand_d = acc_nand_q + ACC_W'(pmon.count_nand);
                    end else begin
                        acc_nor_d = acc_nor_q + ACC_W'(pmon.count_nor);
                    end
                    smp_d   = smp_q + SMP_W'(1);
                    tmr_d   = {TMR_W{1'b0}};
                    state_d = S_REL;
                end else if (tmo_hit_s) begin
                    err_d    = 1'b1;
                    err_ch_d = ch_q;
                    state_d  = S_IDLE;
                end else begin
                    en_nor_d  = ~ch_q;
                    en_nand_d = ch_q;
                end
            end
            S_REL: begin
                if (!done_cur_s) begin
                    state_d = S_NEXT;
                end else if (tmo_hit_s) begin
                    err_d    = 1'b1;
                    err_ch_d = ch_q;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_REL;
                end
            end
            S_NEXT: begin
                tmr_d = {TMR_W{1'b0}};
                if (smp_q < smp_target_s) begin
                    en_nor_d  = ~ch_q;
                    en_nand_d = ch_q;
                    state_d   = S_RUN;
                end else if (!ch_q && sel_q[1]) begin
                    ch_d      = 1'b1;
                    smp_d     = {SMP_W{1'b0}};
                    en_nand_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (sel_q[0]) begin
                    res_nor_d = 24'(acc_nor_q >> avg_q);
                end else begin
                    res_nor_d = res_nor_q;
                end
                if (sel_q[1]) begin
                    res_nand_d = 24'(acc_nand_q >> avg_q);
                end else begin
                    res_nand_d = res_nand_q;
                end
                valid_d = 1'b1;
                tmr_d   = {TMR_W{1'b0}};
                state_d = i_cfg_continuous ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!i_cfg_continuous) begin
                    state_d = S_IDLE;
                end else if (tmr_inc_s >= ival_s) begin
                    if (i_cfg_sel == 2'b00) begin
                        state_d = S_IDLE;
                    end else begin
                        launch_s = 1'b1;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common sequence launch from IDLE start or periodic restart
        if (launch_s) begin
            acc_nor_d  = {ACC_W{1'b0}};
            acc_nand_d = {ACC_W{1'b0}};
            sel_d      = i_cfg_sel;
            avg_d      = avg_clamp_s;
            ch_d       = first_ch_s;
            smp_d      = {SMP_W{1'b0}};
            tmr_d      = {TMR_W{1'b0}};
            en_nor_d   = ~first_ch_s;
            en_nand_d  = first_ch_s;
            state_d    = S_RUN;
        end else begin
            sel_d = sel_d;
        end

        // Abort overrides everything; results and error flag are preserved
        if (i_abort) begin
            state_d    = S_IDLE;
            en_nor_d   = 1'b0;
            en_nand_d  = 1'b0;
            acc_nor_d  = {ACC_W{1'b0}};
            acc_nand_d = {ACC_W{1'b0}};
            valid_d    = 1'b0;
            res_nor_d  = res_nor_q;
            res_nand_d = res_nand_q;
            err_d      = err_q;
            err_ch_d   = err_ch_q;
            tmr_d      = {TMR_W{1'b0}};
        end else begin
            err_d = err_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_refclk or posedge i_refclk_rst) begin
        if (i_refclk_rst) begin
            state_q    <= S_IDLE;
            ch_q       <= 1'b0;
            sel_q      <= 2'b00;
            avg_q      <= 3'd0;
            smp_q      <= {SMP_W{1'b0}};
            tmr_q      <= {TMR_W{1'b0}};
            acc_nor_q  <= {ACC_W{1'b0}};
            acc_nand_q <= {ACC_W{1'b0}};
            en_nor_q   <= 1'b0;
            en_nand_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            res_nor_q  <= 24'd0;
            res_nand_q <= 24'd0;
            err_q      <= 1'b0;
            err_ch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            sel_q      <= sel_d;
            avg_q      <= avg_d;
            smp_q      <= smp_d;
            tmr_q      <= tmr_d;
            acc_nor_q  <= acc_nor_d;
            acc_nand_q <= acc_nand_d;
            en_nor_q   <= en_nor_d;
            en_nand_q  <= en_nand_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            res_nor_q  <= res_nor_d;
            res_nand_q <= res_nand_d;
            err_q      <= err_d;
            err_ch_q   <= err_ch_d;
        end
    end

    assign pmon.en_nor    = en_nor_q;
    assign pmon.en_nand   = en_nand_q;
    assign o_busy         = busy_q;
    assign o_result_valid = valid_q;
    assign o_result_nor   = res_nor_q;
    assign o_result_nand  = res_nand_q;
    assign o_timeout_err  = err_q;
    assign o_timeout_ch   = err_ch_q;
endmodule
